// File: rtl/tsc_exec_core.sv
// tsc_exec_core: TSC CPU execution core - program counter, 4x16 register file, ALU
// Ports: clk, reset_n (async, active-high); pc_jump/pc_target -> pc_out;
//   rf_write/rf_raddr1/rf_raddr2/rf_waddr/rf_wdata -> rf_rdata1/rf_rdata2;
//   alu_in1/alu_in2/alu_cin/alu_op -> alu_result/alu_cout/alu_zero.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module tsc_exec_core #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pc_jump,
  input  logic [11:0]          pc_target,
  output logic [WORD_SIZE-1:0] pc_out,
  input  logic                 rf_write,
  input  logic [1:0]           rf_raddr1,
  input  logic [1:0]           rf_raddr2,
  input  logic [1:0]           rf_waddr,
  input  logic [WORD_SIZE-1:0] rf_wdata,
  output logic [WORD_SIZE-1:0] rf_rdata1,
  output logic [WORD_SIZE-1:0] rf_rdata2,
  input  logic [WORD_SIZE-1:0] alu_in1,
  input  logic [WORD_SIZE-1:0] alu_in2,
  input  logic                 alu_cin,
  input  logic [3:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_result,
  output logic                 alu_cout,
  output logic                 alu_zero
);
  logic [WORD_SIZE-1:0] regs [4];
  logic [WORD_SIZE:0]   sum, dif;
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      pc_out <= '0;
      regs   <= '{default: '0};
    end else begin
      pc_out <= pc_jump ? {pc_out[WORD_SIZE-1:12], pc_target} : pc_out + 1'b1;
      if (rf_write) regs[rf_waddr] <= rf_wdata;
    end
  end
`ifdef RF_BYPASS_EN
  assign rf_rdata1 = (rf_write && rf_raddr1 == rf_waddr) ? rf_wdata : regs[rf_raddr1];
  assign rf_rdata2 = (rf_write && rf_raddr2 == rf_waddr) ? rf_wdata : regs[rf_raddr2];
`else
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
`endif
  // Bit WORD_SIZE of the widened sum/difference is the carry/borrow out
  assign sum = {1'b0, alu_in1} + {1'b0, alu_in2} + {{WORD_SIZE{1'b0}}, alu_cin};
  assign dif = {1'b0, alu_in1} - {1'b0, alu_in2} - {{WORD_SIZE{1'b0}}, alu_cin};
  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_op)
      4'd0: {alu_cout, alu_result} = sum;
      4'd1: {alu_cout, alu_result} = dif;
      4'd2: alu_result = alu_in1 & alu_in2;
      4'd3: alu_result = alu_in1 | alu_in2;
      4'd4: alu_result = ~alu_in1;
      4'd5: alu_result = ~alu_in1 + 1'b1;
      4'd6: alu_result = {alu_in1[WORD_SIZE-2:0], 1'b0};
      4'd7: alu_result = {alu_in1[WORD_SIZE-1], alu_in1[WORD_SIZE-1:1]};
      4'd8: alu_result = {alu_in2[7:0], {(WORD_SIZE-8){1'b0}}};
      4'd9: alu_result = alu_in1;
      default: ;
    endcase
  end
  assign alu_zero = alu_result == '0;
endmodule

// File: tb/tb_tsc_exec_core.sv
// tb_tsc_exec_core: directed self-checking bench for tsc_exec_core
module tb_tsc_exec_core;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        pc_jump = 1'b0;
  logic [11:0] pc_target = '0;
  logic [15:0] pc_out;
  logic        rf_write = 1'b0;
  logic [1:0]  rf_raddr1 = '0, rf_raddr2 = '0, rf_waddr = '0;
  logic [15:0] rf_wdata = '0, rf_rdata1, rf_rdata2;
  logic [15:0] alu_in1 = '0, alu_in2 = '0, alu_result;
  logic        alu_cin = 1'b0, alu_cout, alu_zero;
  logic [3:0]  alu_op = '0;
  int checks = 0, failures = 0;

  tsc_exec_core dut (
    .clk(clk), .reset_n(reset_n), .pc_jump(pc_jump), .pc_target(pc_target), .pc_out(pc_out),
    .rf_write(rf_write), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic j, input logic [11:0] t);
    pc_jump = j;
    pc_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic c,
                     input logic [15:0] res, input logic co, input string tag);
    alu_op = op; alu_in1 = a; alu_in2 = b; alu_cin = c;
    #1;
    check({tag, "_res"}, alu_result, res);
    check({tag, "_cout"}, alu_cout, co);
    check({tag, "_zero"}, alu_zero, res == 16'h0);
  endtask

  initial begin
    #12;
    check("rst_pc", pc_out, 16'h0);
    check("rst_rd1", rf_rdata1, 16'h0);
    @(negedge clk);
    reset_n = 1'b0;
    rf_write = 1'b1; rf_waddr = 2'd3; rf_wdata = 16'h5A5A;
    step(0, 0);
    rf_write = 1'b0; rf_raddr1 = 2'd3;
    repeat (4) step(0, 0);
    check("count_pc5", pc_out, 16'h0005);
    check("r3_pre_rst", rf_rdata1, 16'h5A5A);
    #2;
    reset_n = 1'b1;
    pc_jump = 1'b1; rf_write = 1'b1; rf_wdata = 16'hFFFF;
    #1;
    check("async_rst_pc", pc_out, 16'h0);
    check("async_rst_r3", rf_rdata1, 16'h0);
    @(posedge clk); #1;
    check("rst_dominates_pc", pc_out, 16'h0);
    check("rst_dominates_rf", rf_rdata1, 16'h0);
    rf_write = 1'b0; pc_jump = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    step(0, 0);
    check("post_rst_pc", pc_out, 16'h0001);
    step(1, 12'hFFF);
    check("jump_fff", pc_out, 16'h0FFF);
    step(0, 0);
    check("inc_carry_nibble", pc_out, 16'h1000);
    repeat (2) begin step(1, 12'hFFF); step(0, 0); end
    step(1, 12'hFFE);
    check("pc_3ffe", pc_out, 16'h3FFE);
    step(1, 12'h123);
    check("jump_keep_hi", pc_out, 16'h3123);
    repeat (12) begin step(1, 12'hFFF); step(0, 0); end
    check("pc_f000", pc_out, 16'hF000);
    step(1, 12'hFFF);
    check("pc_ffff", pc_out, 16'hFFFF);
    step(0, 0);
    check("pc_wrap", pc_out, 16'h0000);

    rf_write = 1'b1; rf_waddr = 2'd2; rf_wdata = 16'hBEEF; rf_raddr1 = 2'd2;
    step(0, 0);
    rf_write = 1'b0; rf_wdata = 16'h1111;
    #1;
    check("r2_write", rf_rdata1, 16'hBEEF);
    step(0, 0);
    check("r2_no_we", rf_rdata1, 16'hBEEF);
    rf_write = 1'b1; rf_waddr = 2'd1; rf_wdata = 16'h0055;
    step(0, 0);
    rf_waddr = 2'd0; rf_wdata = 16'h7E01;
    step(0, 0);
    rf_write = 1'b0; rf_raddr1 = 2'd0; rf_raddr2 = 2'd1;
    #1;
    check("r0_port1", rf_rdata1, 16'h7E01);
    check("r1_port2", rf_rdata2, 16'h0055);
    rf_write = 1'b1; rf_waddr = 2'd1; rf_wdata = 16'h00AA; rf_raddr1 = 2'd2;
    #1;
`ifdef RF_BYPASS_EN
    check("same_cycle_rd", rf_rdata2, 16'h00AA);
`else
    check("same_cycle_rd", rf_rdata2, 16'h0055);
`endif
    check("other_port_no_fwd", rf_rdata1, 16'hBEEF);
    step(0, 0);
    rf_write = 1'b0;
    #1;
    check("r1_after", rf_rdata2, 16'h00AA);

    alu(4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "add_wrap");
    alu(4'd0, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, "add_cin");
    alu(4'd1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, "sub_borrow");
    alu(4'd1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, "sub_cin");
    alu(4'd2, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, "and");
    alu(4'd3, 16'hF0F0, 16'h0F00, 1'b0, 16'hFFF0, 1'b0, "orr");
    alu(4'd4, 16'h00FF, 16'h1234, 1'b0, 16'hFF00, 1'b0, "not");
    alu(4'd5, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0, "tcp1");
    alu(4'd5, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, "tcp0");
    alu(4'd6, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1'b0, "shl");
    alu(4'd7, 16'h8002, 16'h0000, 1'b0, 16'hC001, 1'b0, "shr_neg");
    alu(4'd7, 16'h4002, 16'h0000, 1'b0, 16'h2001, 1'b0, "shr_pos");
    alu(4'd8, 16'hFFFF, 16'h5634, 1'b0, 16'h3400, 1'b0, "lhi");
    alu(4'd9, 16'hABCD, 16'h1111, 1'b1, 16'hABCD, 1'b0, "pass");
    alu(4'd12, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, "op12");
    alu(4'd15, 16'h1234, 16'h0001, 1'b1, 16'h0000, 1'b0, "op15");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
